// File: rtl/rom_read_sequencer.sv
// Burst-read engine for the synchronous ROM: walks an address range and streams words on valid/ready.
// Optional running XOR checksum of accepted words is enabled by defining ROM_READ_SEQ_CHECKSUM_EN.
module rom_read_sequencer #(
  parameter int unsigned ADDR_W = 2,
  parameter int unsigned DATA_W = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [ADDR_W-1:0] start_addr,
  input  logic [ADDR_W:0]   num_words,
  output logic              busy,
  output logic              done,
  output logic              rom_en,
  output logic [ADDR_W-1:0] rom_addr,
  input  logic [DATA_W-1:0] rom_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [ADDR_W-1:0] out_addr,
  output logic [DATA_W-1:0] checksum
);

  typedef enum logic [2:0] {IDLE, ISSUE, WAIT, OUT, DONE} state_t;

  localparam logic [ADDR_W:0] DEPTH = {1'b1, {ADDR_W{1'b0}}};

  state_t            state;
  logic [ADDR_W-1:0] cur_addr;
  logic [ADDR_W:0]   remaining;

`ifdef ROM_READ_SEQ_CHECKSUM_EN
  logic [DATA_W-1:0] csum_q;
  assign checksum = csum_q;
`else
  assign checksum = '0;
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= IDLE;
      cur_addr  <= '0;
      remaining <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      rom_en    <= 1'b0;
      rom_addr  <= '0;
      out_valid <= 1'b0;
      out_data  <= '0;
      out_addr  <= '0;
`ifdef ROM_READ_SEQ_CHECKSUM_EN
      csum_q    <= '0;
`endif
    end else begin
      done   <= 1'b0;
      rom_en <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            cur_addr  <= start_addr;
            remaining <= (num_words > DEPTH) ? DEPTH : num_words;
            busy      <= 1'b1;
`ifdef ROM_READ_SEQ_CHECKSUM_EN
            csum_q    <= '0;
`endif
            if (num_words == '0) begin
              state <= DONE;
              done  <= 1'b1;
            end else begin
              state    <= ISSUE;
              rom_en   <= 1'b1;
              rom_addr <= start_addr;
            end
          end
        end
        ISSUE: state <= WAIT;
        WAIT: begin
          out_data  <= rom_data;
          out_addr  <= cur_addr;
          out_valid <= 1'b1;
          state     <= OUT;
        end
        OUT: begin
          if (out_ready) begin
            out_valid <= 1'b0;
`ifdef ROM_READ_SEQ_CHECKSUM_EN
            csum_q    <= csum_q ^ out_data;
`endif
            remaining <= remaining - (ADDR_W+1)'(1);
            if (remaining == (ADDR_W+1)'(1)) begin
              state <= DONE;
              done  <= 1'b1;
            end else begin
              // rom_en/rom_addr are registered, so the next issue is set up on the handshake edge
              cur_addr <= cur_addr + ADDR_W'(1);
              rom_addr <= cur_addr + ADDR_W'(1);
              rom_en   <= 1'b1;
              state    <= ISSUE;
            end
          end
        end
        DONE: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_rom_read_sequencer.sv
// Scoreboard bench for rom_read_sequencer against a 4x4 synchronous ROM model.
module tb_rom_read_sequencer;
  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic [1:0] start_addr = '0;
  logic [2:0] num_words = '0;
  logic       busy, done, rom_en, out_valid;
  logic [1:0] rom_addr, out_addr;
  logic [3:0] rom_data = '0;
  logic       out_ready = 1'b1;
  logic [3:0] out_data, checksum;

  logic [3:0] mem [4];
  logic [5:0] exp_q [$];
  int total = 0;
  int bad = 0;

  rom_read_sequencer #(.ADDR_W(2), .DATA_W(4)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .start_addr(start_addr),
    .num_words(num_words), .busy(busy), .done(done), .rom_en(rom_en),
    .rom_addr(rom_addr), .rom_data(rom_data), .out_valid(out_valid),
    .out_ready(out_ready), .out_data(out_data), .out_addr(out_addr),
    .checksum(checksum)
  );

  always #5 clk = ~clk;

  initial begin
    mem[0] = 4'hA; mem[1] = 4'h5; mem[2] = 4'hC; mem[3] = 4'h3;
  end

  always @(posedge clk) if (rom_en) rom_data <= mem[rom_addr];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic push(input logic [1:0] a, input logic [3:0] d);
    exp_q.push_back({a, d});
  endtask

  function automatic logic [3:0] exp_cs(input logic [3:0] v);
`ifdef ROM_READ_SEQ_CHECKSUM_EN
    return v;
`else
    return 4'h0;
`endif
  endfunction

  // Monitor: pop and compare on each handshake
  always @(negedge clk) begin
    logic [5:0] e;
    if (rst_n && out_valid && out_ready) begin
      if (exp_q.size() == 0) chk("unexpected_word", 1, 0);
      else begin
        e = exp_q.pop_front();
        chk("word_data", 32'(out_data), 32'(e[3:0]));
        chk("word_addr", 32'(out_addr), 32'(e[5:4]));
      end
    end
  end

  // Called at posedge+1 with state IDLE; returns at posedge+1 one cycle after done.
  task automatic run_burst(input logic [1:0] sa, input logic [2:0] nw, input int exp_cyc,
                           input logic [3:0] cs, input bit access, input int stall,
                           input logic [3:0] hold_d, input logic [1:0] hold_a);
    int cyc;
    int stall_left;
    bit saw_en, saw_v;
    logic [3:0] cs_done;
    saw_en = 0; saw_v = 0; stall_left = stall;
    start_addr = sa; num_words = nw; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    cyc = 1;
    chk("busy_after_start", 32'(busy), 1);
    while (!done && cyc < 200) begin
      saw_en |= rom_en;
      saw_v  |= out_valid;
      if (out_valid && stall_left > 0) begin
        chk("stall_valid", 32'(out_valid), 1);
        chk("stall_data", 32'(out_data), 32'(hold_d));
        chk("stall_addr", 32'(out_addr), 32'(hold_a));
        stall_left--;
      end else if (stall_left == 0) out_ready = 1'b1;
      @(posedge clk); #1;
      cyc++;
    end
    chk("done_seen", 32'(done), 1);
    chk("done_cycle", 32'(cyc), 32'(exp_cyc));
    chk("busy_in_done", 32'(busy), 1);
    chk("rom_access", 32'(saw_en | saw_v), 32'(access));
    cs_done = checksum;
    chk("checksum", 32'(cs_done), 32'(exp_cs(cs)));
    @(posedge clk); #1;
    chk("done_one_cycle", 32'(done), 0);
    chk("busy_idle", 32'(busy), 0);
    chk("checksum_stable", 32'(checksum), 32'(exp_cs(cs)));
    chk("queue_drained", 32'(exp_q.size()), 0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_outputs", 32'({busy, done, rom_en, out_valid, rom_addr, out_data, out_addr, checksum}), 0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    push(2'd0, 4'hA); push(2'd1, 4'h5); push(2'd2, 4'hC); push(2'd3, 4'h3);
    run_burst(2'd0, 3'd4, 13, 4'h0, 1, 0, 4'h0, 2'd0);

    push(2'd3, 4'h3); push(2'd0, 4'hA); push(2'd1, 4'h5);
    run_burst(2'd3, 3'd3, 10, 4'hC, 1, 0, 4'h0, 2'd0);

    out_ready = 1'b0;
    push(2'd1, 4'h5); push(2'd2, 4'hC);
    run_burst(2'd1, 3'd2, 11, 4'h9, 1, 4, 4'h5, 2'd1);

    run_burst(2'd2, 3'd0, 1, 4'h0, 0, 0, 4'h0, 2'd0);

    push(2'd2, 4'hC); push(2'd3, 4'h3); push(2'd0, 4'hA); push(2'd1, 4'h5);
    run_burst(2'd2, 3'd7, 13, 4'h0, 1, 0, 4'h0, 2'd0);

    // Reset during the second word's WAIT cycle
    push(2'd0, 4'hA);
    start_addr = 2'd0; num_words = 3'd4; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (4) begin
      chk("no_early_done", 32'(done), 0);
      @(posedge clk); #1;
    end
    chk("in_wait_en_low", 32'({rom_en, out_valid}), 0);
    rst_n = 1'b0;
    @(posedge clk); #1;
    chk("reset_midburst", 32'({busy, done, rom_en, out_valid, rom_addr, out_data, out_addr, checksum}), 0);
    rst_n = 1'b1;
    chk("reset_queue", 32'(exp_q.size()), 0);
    @(posedge clk); #1;
    chk("no_done_after_reset", 32'(done), 0);

    push(2'd0, 4'hA);
    run_burst(2'd0, 3'd1, 4, 4'hA, 1, 0, 4'h0, 2'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/rom_read_sequencer.md
# rom_read_sequencer

Upstream controller for the team's synchronous ROM (the 4x4 `ROM_4x4` and its larger variants). On a start request it walks a contiguous address range and drives the ROM's `en` and `address`. It captures each word from the ROM's `data_out` one cycle after issue and presents it downstream on a valid/ready handshake. It replaces hand-driven address stimulus with a reusable burst-read engine.

## Interface
- `ADDR_W`, 2: ROM address width; ROM depth = 2^ADDR_W.
- `DATA_W`, 4: ROM word width.

- `clk` input 1: single clock, all logic on rising edge.
- `rst_n` input 1: synchronous, active-low reset.
- `start` input 1: request a burst; sampled only in IDLE.
- `start_addr` input ADDR_W: first address of burst, latched on accepted start.
- `num_words` input ADDR_W+1: words to read, latched on accepted start.
- `busy` output 1: high in every state except IDLE.
- `done` output 1: one-cycle pulse at burst completion.
- `rom_en` output 1: to ROM `en`.
- `rom_addr` output ADDR_W: to ROM `address`.
- `rom_data` input DATA_W: from ROM `data_out`. The ROM registers on the rising edge where `en`=1.
- `out_valid` output 1: captured word available.
- `out_ready` input 1: downstream accepts the word.
- `out_data` output DATA_W: captured word.
- `out_addr` output ADDR_W: address the word was read from.
- `checksum` output DATA_W: see Configuration.

## Operation
- FSM states: IDLE, ISSUE, WAIT, OUT, DONE.
- IDLE:
  - On `start`=1: latch `start_addr` into `cur_addr`.
  - Latch `remaining` = min(`num_words`, 2^ADDR_W).
  - Clear the checksum.
  - Go to ISSUE, or to DONE if `num_words`=0.
- ISSUE: `rom_en`=1 and `rom_addr`=`cur_addr` for exactly one cycle, then go to WAIT.
- WAIT: `rom_en`=0. At the end of the cycle, register `rom_data` into `out_data` and `cur_addr` into `out_addr`, set `out_valid`, and go to OUT.
- OUT: `out_valid`=1. While `out_ready`=0, hold `out_data`/`out_addr` stable. On `out_valid & out_ready`:
  - decrement `remaining`;
  - if the result is 0, go to DONE;
  - otherwise `cur_addr` <= `cur_addr`+1 (mod 2^ADDR_W, wrapping 2^ADDR_W-1 to 0) and go to ISSUE.
  - `out_valid` drops in the cycle after the handshake.
- DONE: `done`=1 for one cycle, then go to IDLE. `busy` is still high in DONE.
- `start` outside IDLE is ignored; no queuing.
- `rom_addr` holds its last value when `rom_en`=0.
- `num_words` values above 2^ADDR_W saturate to 2^ADDR_W. Each address is read at most once per burst.

## Timing
- Reset values (`rst_n` low at a rising edge): state=IDLE; `busy`, `done`, `rom_en`, `out_valid`=0; `rom_addr`, `out_data`, `out_addr`, `checksum`=0.
- Reset mid-burst aborts the burst on the next edge. No `done` pulse is generated.
- Start accepted at edge T:
  - ISSUE in cycle T+1.
  - First `out_valid` in cycle T+3.
- With `out_ready` tied high:
  - 3 cycles per word.
  - An N-word burst has `done` in cycle T+3N+1.
- `num_words`=0: `done` in cycle T+1, no ROM access.
- Back-to-back bursts: the earliest next start is accepted in the cycle after `done`, when state is IDLE.

## Configuration
- Macro `ROM_READ_SEQ_CHECKSUM_EN`.
- Defined:
  - `checksum` is the running XOR of every word accepted downstream in the current burst.
  - It is cleared on an accepted start and is final and stable from the `done` cycle until the next accepted start.
- Undefined: `checksum` is driven constant 0 and no accumulator is built.

## Test plan
Bench ROM model contents: mem[0]=4'hA, mem[1]=4'h5, mem[2]=4'hC, mem[3]=4'h3.
- Reset then `start_addr`=0, `num_words`=4, `out_ready`=1:
  - outputs A,5,C,3 with `out_addr` 0..3;
  - `done` at T+13;
  - `checksum`=4'h0 with the macro defined.
- `start_addr`=3, `num_words`=3: outputs 3,A,5 from addresses 3,0,1 (wrap). `checksum`=4'hC.
- `start_addr`=1, `num_words`=2, `out_ready` low for 4 cycles on the first word: `out_data`=5 held stable with `out_valid`=1, then C follows and `done` pulses once.
- `num_words`=0 with `start`: `done` at T+1, `rom_en` never asserted, `out_valid` never asserted.
- `num_words`=7, `start_addr`=2: exactly 4 words (C,3,A,5), then `done`.
- `rst_n` low during second-word WAIT: all outputs 0 next cycle. A new start with `start_addr`=0, `num_words`=1 yields A and `done`.
